// File: rtl/cp0_pkg.sv
// ---------------------------------------------------------------------------
// cp0_pkg -- shared CP0 constants and register layouts.
//   Register numbers for mtc0/mfc0, ExcCode values, the exception handler
//   address, and packed views of the SR and Cause registers with helpers
//   that expand them to their architectural 32-bit read format.
// ---------------------------------------------------------------------------
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Where the next-PC unit redirects to when req is raised
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // Only the implemented SR fields are stored
  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  // Only the implemented Cause fields are stored
  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  // SR read format: IM=[15:10], EXL=[1], IE=[0], everything else zero
  function automatic logic [31:0] pack_sr(input sr_t s);
    return {16'b0, s.im, 8'b0, s.exl, s.ie};
  endfunction

  // Cause read format: BD=[31], IP=[15:10], ExcCode=[6:2], everything else zero
  function automatic logic [31:0] pack_cause(input cause_t c);
    return {c.bd, 15'b0, c.ip, 3'b0, c.exc_code, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// ---------------------------------------------------------------------------
// int_sync -- two-stage synchronizer for the external interrupt lines.
//   clk   : destination clock, rising edge
//   reset : asynchronous active-low reset, clears both stages
//   d     : asynchronous input lines
//   q     : synchronized lines, two clocks of latency
// ---------------------------------------------------------------------------
module int_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cp0.sv
// ---------------------------------------------------------------------------
// cp0 -- minimal MIPS-style coprocessor 0: SR, Cause, EPC, PRId, interrupt
// and exception entry, eret.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   we       : mtc0 write strobe
//   addr     : CP0 register number for mtc0/mfc0
//   wdata    : mtc0 data
//   rdata    : mfc0 data (combinational)
//   pc_in    : PC of the committing instruction
//   pc_valid : pc_in is a real instruction, not a bubble
//   bd_in    : committing instruction sits in a delay slot
//   exc_in   : ExcCode of a synchronous exception, 0 = none
//   hw_int   : asynchronous external interrupt lines
//   eret     : eret commits this cycle
//   req      : redirect to HANDLER_ADDR (combinational)
//   epc_out  : current EPC, used by the next-PC unit on eret
// ---------------------------------------------------------------------------
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  input  logic        bd_in,
  input  logic [4:0]  exc_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out
);

  sr_t         sr;
  cause_t      cause;
  logic [31:0] epc;
  logic [5:0]  hw_sync;
  logic        int_req;
  logic        exc_req;

  int_sync #(.W(6)) u_int_sync (
    .clk   (clk),
    .reset (reset),
    .d     (hw_int),
    .q     (hw_sync)
  );

  // EXL masks both sources, so a handler can never be re-entered.
  assign int_req = (|(cause.ip & sr.im)) & sr.ie & ~sr.exl & pc_valid;
  assign exc_req = (exc_in != EXC_INT) & ~sr.exl;
  // A pending exc_in must not leak out while the block is held in reset.
  assign req     = (int_req | exc_req) & reset;

  assign epc_out = epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr    <= '0;
      cause <= '0;
      epc   <= '0;
    end else begin
      cause.ip <= hw_sync;
      if (req) begin
        // Exception entry wins over any mtc0 or eret in the same cycle.
        sr.exl         <= 1'b1;
        cause.bd       <= bd_in;
        cause.exc_code <= int_req ? EXC_INT : exc_in;
        epc            <= bd_in ? pc_in - 32'd4 : pc_in;
      end else begin
        if (we && addr == REG_SR) begin
          sr.im  <= wdata[15:10];
          sr.exl <= wdata[1];
          sr.ie  <= wdata[0];
        end
        if (we && addr == REG_EPC) begin
          epc <= wdata;
        end
        // Placed after the SR write: the last non-blocking assignment wins,
        // so eret clears EXL even when the same cycle writes SR.
        if (eret) begin
          sr.exl <= 1'b0;
        end
      end
    end
  end

  // NOTE: every path assigns rdata after the default, so no latch is inferred.
  always_comb begin
    rdata = '0;
    case (addr)
      REG_SR:    rdata = pack_sr(sr);
      REG_CAUSE: rdata = pack_cause(cause);
      REG_EPC:   rdata = epc;
      REG_PRID:  rdata = PRID;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// ---------------------------------------------------------------------------
// tb_cp0 -- self-checking bench for cp0: directed scenarios followed by
// randomized traffic, all compared against a word-level reference model.
// ---------------------------------------------------------------------------
module tb_cp0;

  localparam logic [31:0] PRID_VAL = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        bd_in;
  logic [4:0]  exc_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] epc_out;

  int checks = 0;
  int errors = 0;

  cp0 #(.PRID(PRID_VAL)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .pc_in    (pc_in),
    .pc_valid (pc_valid),
    .bd_in    (bd_in),
    .exc_in   (exc_in),
    .hw_int   (hw_int),
    .eret     (eret),
    .req      (req),
    .epc_out  (epc_out)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (architectural words) ----------------
  logic [31:0] m_sr, m_cause, m_epc;
  logic [5:0]  ip_pipe[$];   // IP values still in flight through the synchronizer
  logic        m_req, m_int;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_sr    = 32'h0;
    m_cause = 32'h0;
    m_epc   = 32'h0;
    ip_pipe = {};
    ip_pipe.push_back(6'h00);
    ip_pipe.push_back(6'h00);
  endtask

  task automatic model_eval();
    logic exl, ie;
    exl   = m_sr[1];
    ie    = m_sr[0];
    m_int = ((m_cause[15:10] & m_sr[15:10]) != 6'h00) && ie && !exl && pc_valid;
    m_req = m_int || ((exc_in != 5'd0) && !exl);
  endtask

  task automatic model_edge();
    logic [5:0] new_ip;
    ip_pipe.push_back(hw_int);
    new_ip = ip_pipe.pop_front();
    if (m_req) begin
      m_sr[1]       = 1'b1;
      m_cause[31]   = bd_in;
      m_cause[6:2]  = m_int ? 5'd0 : exc_in;
      m_epc         = bd_in ? pc_in - 32'd4 : pc_in;
    end else begin
      if (we && addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
      if (we && addr == 5'd14) m_epc = wdata;
      if (eret) m_sr[1] = 1'b0;
    end
    m_cause[15:10] = new_ip;
  endtask

  // One clock: compare combinational outputs mid-cycle, then advance.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    check("req", {31'b0, req}, {31'b0, m_req});
    check("epc_out", epc_out, m_epc);
    check("rdata", rdata, m_read(addr));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Reset pulse entirely between two rising edges (called just after cycle()).
  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_req", {31'b0, req}, 32'h0);
    check("rst_epc_out", epc_out, 32'h0);
    addr = 5'd12; #1; check("rst_sr", rdata, 32'h0);
    addr = 5'd13; #1; check("rst_cause", rdata, 32'h0);
    addr = 5'd14; #1; check("rst_epc", rdata, 32'h0);
    reset = 1'b1;
    addr = 5'd15; #1; check("post_rst_prid", rdata, PRID_VAL);
    check("post_rst_req", {31'b0, req}, {31'b0, (exc_in != 5'd0)});
  endtask

  task automatic idle_inputs();
    we = 1'b0; addr = 5'd0; wdata = 32'h0; pc_in = 32'h0; pc_valid = 1'b0;
    bd_in = 1'b0; exc_in = 5'd0; hw_int = 6'h00; eret = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_req", {31'b0, req}, 32'h0);
    check("reset_epc_out", epc_out, 32'h0);
    reset = 1'b1;

    // Scenario 1: interrupt through the synchronizer
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
    cycle();
    we = 1'b0; addr = 5'd13; hw_int = 6'h01; pc_valid = 1'b1; pc_in = 32'h0000_3010;
    cycle(); cycle();
    check("s1_no_req_yet", {31'b0, req}, 32'h0);
    cycle();
    check("s1_req", {31'b0, req}, 32'h1);
    cycle();
    pc_valid = 1'b0; hw_int = 6'h00;
    addr = 5'd14; #1; check("s1_epc", rdata, 32'h0000_3010);
    addr = 5'd12; #1; check("s1_sr", rdata, 32'h0000_0403);
    addr = 5'd13; #1; check("s1_cause", rdata, 32'h0000_0400);
    repeat (3) cycle();
    eret = 1'b1; cycle(); eret = 1'b0;

    // Scenario 2: synchronous exception in a delay slot
    exc_in = 5'd12; bd_in = 1'b1; pc_in = 32'h0000_3024; pc_valid = 1'b1;
    #1; check("s2_req", {31'b0, req}, 32'h1);
    cycle();
    exc_in = 5'd0; bd_in = 1'b0;
    addr = 5'd14; #1; check("s2_epc", rdata, 32'h0000_3020);
    addr = 5'd13; #1; check("s2_cause", rdata, 32'h8000_0030);
    eret = 1'b1; cycle(); eret = 1'b0;

    // Scenario 4: mtc0 EPC colliding with an exception is lost
    we = 1'b1; addr = 5'd14; wdata = 32'h0000_3100; exc_in = 5'd10; pc_in = 32'h0000_3040;
    cycle();
    we = 1'b0; exc_in = 5'd0;
    #1; check("s4_epc_out", epc_out, 32'h0000_3040);
    check("s4_rdata", rdata, 32'h0000_3040);
    eret = 1'b1; cycle(); eret = 1'b0;

    // eret together with an SR write: written value, then EXL cleared
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0403; eret = 1'b1;
    cycle();
    we = 1'b0; eret = 1'b0;
    #1; check("eret_sr_write", rdata, 32'h0000_0401);
    // Cause and PRId are not writable
    we = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF; cycle();
    addr = 5'd15; cycle();
    we = 1'b0;
    #1; check("prid_ro", rdata, PRID_VAL);
    addr = 5'd13; #1; check("cause_ro", rdata, 32'h0000_0028);

    // Scenario 5: interrupt blocked by a bubble
    hw_int = 6'h01; pc_valid = 1'b0;
    repeat (4) cycle();
    check("s5_bubble", {31'b0, req}, 32'h0);
    pc_valid = 1'b1; pc_in = 32'h0000_3060;
    #1; check("s5_req", {31'b0, req}, 32'h1);
    cycle();

    // Scenario 3: nothing nests while EXL=1; eret releases the pending interrupt
    exc_in = 5'd4;
    #1; check("s3_exc_masked", {31'b0, req}, 32'h0);
    cycle();
    exc_in = 5'd0;
    repeat (2) cycle();
    check("s3_int_masked", {31'b0, req}, 32'h0);
    eret = 1'b1; cycle(); eret = 1'b0;
    #1; check("s3_req_after_eret", {31'b0, req}, 32'h1);
    cycle();

    // Scenario 6: reset mid-handler with EPC=0x3050, no clock edge
    we = 1'b1; addr = 5'd14; wdata = 32'h0000_3050; cycle();
    we = 1'b0; hw_int = 6'h00; pc_valid = 1'b0;
    #1; check("s6_pre_epc", epc_out, 32'h0000_3050);
    pulse_reset();
    addr = 5'd12; #1; check("s6_sr_after", rdata, 32'h0);
    check("s6_epc_after", epc_out, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [4:0] regs[4];
      logic [4:0] codes[4];
      regs  = '{5'd12, 5'd13, 5'd14, 5'd15};
      codes = '{5'd4, 5'd5, 5'd10, 5'd12};
      we    = ($urandom_range(3) == 0);
      addr  = ($urandom_range(4) == 0) ? 5'($urandom) : regs[$urandom_range(3)];
      wdata = $urandom;
      if ($urandom_range(5) == 0)
        exc_in = ($urandom_range(3) == 0) ? 5'($urandom) : codes[$urandom_range(3)];
      else
        exc_in = 5'd0;
      bd_in    = 1'($urandom);
      pc_in    = $urandom & 32'hFFFF_FFFC;
      pc_valid = ($urandom_range(3) != 0);
      eret     = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) hw_int = 6'($urandom);
      cycle();
      if ($urandom_range(99) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
